mem_stage_sram_ctrl: RTL and testbench

Consumer end of the EXE/MEM pipeline interface. Takes the registered EXE outputs (dest, val_rm, ALU_res, MEM_W, MEM_R, WB_EN) and performs the data-memory access against an external 16-bit asynchronous SRAM. Each 32-bit word is accessed as two half-word transfers. While an access is in progress, the block stalls the pipeline through `freeze`. The block also contains the MEM/WB pipeline register that feeds write-back.

---
 rtl/mem_stage_sram_ctrl_pkg.sv | 25 ++
 rtl/mem_stage_sram_ctrl_sram_half_xfer.sv | 79 +++++++
 rtl/mem_stage_sram_ctrl.sv | 130 +++++++++++++
 tb/tb_mem_stage_sram_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_sram_ctrl_pkg.sv
// Shared MEM-stage definitions: FSM state encoding, the default data-memory
// base address, and the MEM/WB bundle layout that the WB mux also uses.
package mem_stage_sram_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } mem_state_t;

  localparam int unsigned BASE_ADDR_DEFAULT = 1024;
  localparam int unsigned DEST_W            = 4;
  localparam int unsigned WORD_W            = 32;
  localparam int unsigned HALF_W            = 16;

  typedef struct packed {
    logic              wb_en;
    logic              mem_r;
    logic [DEST_W-1:0] dest;
    logic [WORD_W-1:0] alu_res;
    logic [WORD_W-1:0] mem_data;
  } mem_wb_t;

endpackage

// File: rtl/mem_stage_sram_ctrl_sram_half_xfer.sv
// One half-word SRAM transfer phase: wait counter, pin drive and read latching.
// phase_done pulses on the last wait cycle of the active phase.
module sram_half_xfer
  import mem_stage_sram_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               active,
  input  logic               half,
  input  logic               is_store,
  input  logic               is_load,
  input  logic [SRAM_AW-2:0] word,
  input  logic [WORD_W-1:0]  val_rm,
  input  logic [HALF_W-1:0]  sram_dq_in,
  output logic               phase_done,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [HALF_W-1:0]  sram_dq_out,
  output logic               sram_dq_oe,
  output logic               sram_we_n,
  output logic               sram_oe_n,
  output logic [HALF_W-1:0]  rd_lo,
  output logic [HALF_W-1:0]  rd_hi
);

  localparam int unsigned CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);

  logic [CW-1:0] cnt;

  assign phase_done = active && (cnt == LAST);

  // Wait counter: runs only inside a phase, restarts for each half.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!active || phase_done) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Read data is captured on the final wait cycle of the matching half.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_lo <= '0;
      rd_hi <= '0;
    end else if (phase_done && is_load) begin
      if (half) begin
        rd_hi <= sram_dq_in;
      end else begin
        rd_lo <= sram_dq_in;
      end
    end
  end

  // SRAM pins are driven only during an active phase; idle otherwise.
  always_comb begin
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    sram_oe_n   = 1'b1;
    if (active) begin
      sram_addr = {word, half};
      if (is_store) begin
        sram_we_n   = 1'b0;
        sram_dq_oe  = 1'b1;
        sram_dq_out = half ? val_rm[31:16] : val_rm[15:0];
      end else if (is_load) begin
        sram_oe_n = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// MEM stage: sequences a 32-bit data access as two 16-bit SRAM transfers,
// stalls the pipeline while it runs, and holds the MEM/WB register.
module mem_stage_sram_ctrl
  import mem_stage_sram_ctrl_pkg::*;
#(
  parameter int unsigned BASE_ADDR   = BASE_ADDR_DEFAULT,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_r_in,
  input  logic               mem_w_in,
  input  logic               wb_en_in,
  input  logic [DEST_W-1:0]  dest_in,
  input  logic [WORD_W-1:0]  alu_res_in,
  input  logic [WORD_W-1:0]  val_rm_in,
  output logic               freeze,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [HALF_W-1:0]  sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [HALF_W-1:0]  sram_dq_in,
  output logic               sram_we_n,
  output logic               sram_oe_n,
  output logic               wb_en_out,
  output logic               mem_r_out,
  output logic [DEST_W-1:0]  dest_out,
  output logic [WORD_W-1:0]  alu_res_out,
  output logic [WORD_W-1:0]  mem_data_out
);

  localparam logic [WORD_W-1:0] BASE_L = WORD_W'(BASE_ADDR);

  mem_state_t         state, state_nx;
  mem_wb_t            mem_wb;
  logic               op;
  logic               is_store;
  logic               is_load;
  logic               active;
  logic               phase_done;
  logic [SRAM_AW-2:0] word;
  logic [HALF_W-1:0]  rd_lo, rd_hi;

  assign op       = mem_r_in | mem_w_in;
  assign is_store = mem_w_in;
  assign is_load  = mem_r_in & ~mem_w_in;
  assign active   = (state == LO) || (state == HI);
  // Wrapping subtraction, then drop the byte offset and keep the SRAM word bits.
  assign word     = (SRAM_AW-1)'((alu_res_in - BASE_L) >> 2);

  sram_half_xfer #(
    .WAIT_CYCLES(WAIT_CYCLES),
    .SRAM_AW    (SRAM_AW)
  ) u_xfer (
    .clk        (clk),
    .rst        (rst),
    .active     (active),
    .half       (state == HI),
    .is_store   (is_store),
    .is_load    (is_load),
    .word       (word),
    .val_rm     (val_rm_in),
    .sram_dq_in (sram_dq_in),
    .phase_done (phase_done),
    .sram_addr  (sram_addr),
    .sram_dq_out(sram_dq_out),
    .sram_dq_oe (sram_dq_oe),
    .sram_we_n  (sram_we_n),
    .sram_oe_n  (sram_oe_n),
    .rd_lo      (rd_lo),
    .rd_hi      (rd_hi)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state and stall; freeze is masked during reset so it reads 0 then.
  always_comb begin
    state_nx = state;
    freeze   = 1'b0;
    case (state)
      IDLE: begin
        if (op) begin
          state_nx = LO;
          freeze   = 1'b1;
        end
      end
      LO: begin
        freeze = 1'b1;
        if (phase_done) state_nx = HI;
      end
      HI: begin
        freeze = 1'b1;
        if (phase_done) state_nx = DONE;
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (rst) freeze = 1'b0;
  end

  // MEM/WB register: bubble while stalled so write-back fires once per op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_wb <= '0;
    end else if (freeze) begin
      mem_wb.wb_en <= 1'b0;
      mem_wb.mem_r <= 1'b0;
    end else begin
      mem_wb.wb_en    <= wb_en_in;
      mem_wb.mem_r    <= mem_r_in;
      mem_wb.dest     <= dest_in;
      mem_wb.alu_res  <= alu_res_in;
      mem_wb.mem_data <= {rd_hi, rd_lo};
    end
  end

  assign wb_en_out    = mem_wb.wb_en;
  assign mem_r_out    = mem_wb.mem_r;
  assign dest_out     = mem_wb.dest;
  assign alu_res_out  = mem_wb.alu_res;
  assign mem_data_out = mem_wb.mem_data;

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Directed bench for mem_stage_sram_ctrl with a behavioural 16-bit SRAM.
module tb_mem_stage_sram_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_r_in, mem_w_in, wb_en_in;
  logic [3:0]  dest_in;
  logic [31:0] alu_res_in, val_rm_in;
  logic        freeze;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_we_n, sram_oe_n;
  logic        wb_en_out, mem_r_out;
  logic [3:0]  dest_out;
  logic [31:0] alu_res_out, mem_data_out;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] sram [0:262143];

  always #5 clk = ~clk;

  mem_stage_sram_ctrl #(
    .BASE_ADDR  (1024),
    .WAIT_CYCLES(2),
    .SRAM_AW    (18)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_r_in    (mem_r_in),
    .mem_w_in    (mem_w_in),
    .wb_en_in    (wb_en_in),
    .dest_in     (dest_in),
    .alu_res_in  (alu_res_in),
    .val_rm_in   (val_rm_in),
    .freeze      (freeze),
    .sram_addr   (sram_addr),
    .sram_dq_out (sram_dq_out),
    .sram_dq_oe  (sram_dq_oe),
    .sram_dq_in  (sram_dq_in),
    .sram_we_n   (sram_we_n),
    .sram_oe_n   (sram_oe_n),
    .wb_en_out   (wb_en_out),
    .mem_r_out   (mem_r_out),
    .dest_out    (dest_out),
    .alu_res_out (alu_res_out),
    .mem_data_out(mem_data_out)
  );

  assign sram_dq_in = sram_oe_n ? 16'h0000 : sram[sram_addr];

  always @(posedge clk) begin
    if (!sram_we_n && sram_dq_oe) sram[sram_addr] <= sram_dq_out;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic w, input logic wb,
                       input logic [3:0] d, input logic [31:0] a, input logic [31:0] v);
    mem_r_in   = r;
    mem_w_in   = w;
    wb_en_in   = wb;
    dest_in    = d;
    alu_res_in = a;
    val_rm_in  = v;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 1'b1, 1'b1, 4'd6, 32'd1028, 32'h11112222);
    tick();
    tick();
    @(negedge clk);
    n_cmp++;
    if (freeze !== 1'b0) begin
      n_err++; $display("FAIL reset_freeze got=%b exp=0", freeze);
    end
    n_cmp++;
    if ({sram_we_n, sram_oe_n, sram_dq_oe} !== 3'b110) begin
      n_err++; $display("FAIL reset_ctl got=%b exp=110", {sram_we_n, sram_oe_n, sram_dq_oe});
    end
    n_cmp++;
    if ({sram_addr, sram_dq_out} !== 34'h0) begin
      n_err++; $display("FAIL reset_bus got=%h exp=0", {sram_addr, sram_dq_out});
    end
    n_cmp++;
    if ({wb_en_out, mem_r_out, dest_out, alu_res_out, mem_data_out} !== 70'h0) begin
      n_err++; $display("FAIL reset_memwb got=%h exp=0",
                        {wb_en_out, mem_r_out, dest_out, alu_res_out, mem_data_out});
    end
    drive(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    tick();
    rst = 1'b0;
  endtask

  task automatic test_nonmem();
    tick();
    drive(1'b0, 1'b0, 1'b1, 4'd5, 32'h1234, 32'd0);
    @(negedge clk);
    n_cmp++;
    if (freeze !== 1'b0) begin
      n_err++; $display("FAIL nonmem_freeze got=%b exp=0", freeze);
    end
    tick();
    drive(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    @(negedge clk);
    n_cmp++;
    if ({wb_en_out, mem_r_out, dest_out, alu_res_out} !== {1'b1, 1'b0, 4'd5, 32'h1234}) begin
      n_err++; $display("FAIL nonmem_wb got=%b/%b/%0d/%h exp=1/0/5/1234",
                        wb_en_out, mem_r_out, dest_out, alu_res_out);
    end
    n_cmp++;
    if (freeze !== 1'b0) begin
      n_err++; $display("FAIL nonmem_freeze2 got=%b exp=0", freeze);
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if (wb_en_out !== 1'b0) begin
      n_err++; $display("FAIL nonmem_once got=%b exp=0", wb_en_out);
    end
  endtask

  task automatic test_store();
    tick();
    drive(1'b0, 1'b1, 1'b0, 4'd0, 32'd1028, 32'hDEADBEEF);
    for (int c = 0; c < 6; c++) begin
      logic        ef, ephase;
      logic [17:0] ea;
      logic [15:0] ed;
      ef     = (c < 5);
      ephase = (c >= 1 && c <= 4);
      ea     = (c == 1 || c == 2) ? 18'd2 : (c == 3 || c == 4) ? 18'd3 : 18'd0;
      ed     = (c == 1 || c == 2) ? 16'hBEEF : (c == 3 || c == 4) ? 16'hDEAD : 16'h0;
      @(negedge clk);
      n_cmp++;
      if (freeze !== ef) begin
        n_err++; $display("FAIL store_freeze c=%0d got=%b exp=%b", c, freeze, ef);
      end
      n_cmp++;
      if ({sram_we_n, sram_dq_oe, sram_oe_n, sram_addr, sram_dq_out} !==
          {~ephase, ephase, 1'b1, ea, ed}) begin
        n_err++; $display("FAIL store_pins c=%0d got=%b/%b/%b/%h/%h exp=%b/%b/1/%h/%h", c,
                          sram_we_n, sram_dq_oe, sram_oe_n, sram_addr, sram_dq_out,
                          ~ephase, ephase, ea, ed);
      end
      n_cmp++;
      if (wb_en_out !== 1'b0) begin
        n_err++; $display("FAIL store_bubble c=%0d got=%b exp=0", c, wb_en_out);
      end
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    @(negedge clk);
    n_cmp++;
    if ({sram[2], sram[3]} !== 32'hBEEFDEAD) begin
      n_err++; $display("FAIL store_mem got=%h exp=beefdead", {sram[2], sram[3]});
    end
  endtask

  task automatic test_load();
    tick();
    drive(1'b1, 1'b0, 1'b1, 4'd7, 32'd1028, 32'd0);
    for (int c = 0; c < 6; c++) begin
      logic ef, eoe_n;
      ef    = (c < 5);
      eoe_n = !(c >= 1 && c <= 4);
      @(negedge clk);
      n_cmp++;
      if ({freeze, sram_oe_n, sram_we_n, wb_en_out} !== {ef, eoe_n, 1'b1, 1'b0}) begin
        n_err++; $display("FAIL load_cycle c=%0d got=%b exp=%b", c,
                          {freeze, sram_oe_n, sram_we_n, wb_en_out}, {ef, eoe_n, 1'b1, 1'b0});
      end
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    @(negedge clk);
    n_cmp++;
    if (mem_data_out !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL load_data got=%h exp=deadbeef", mem_data_out);
    end
    n_cmp++;
    if ({wb_en_out, mem_r_out, dest_out} !== {1'b1, 1'b1, 4'd7}) begin
      n_err++; $display("FAIL load_ctl got=%b/%b/%0d exp=1/1/7", wb_en_out, mem_r_out, dest_out);
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if ({wb_en_out, mem_r_out} !== 2'b00) begin
      n_err++; $display("FAIL load_once got=%b exp=00", {wb_en_out, mem_r_out});
    end
  endtask

  task automatic test_back_to_back();
    int wb_seen;
    wb_seen = 0;
    tick();
    drive(1'b1, 1'b0, 1'b1, 4'd3, 32'd1028, 32'd0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (wb_en_out === 1'b1) wb_seen++;
      tick();
    end
    drive(1'b0, 1'b1, 1'b0, 4'd0, 32'd1032, 32'h0BADF00D);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (wb_en_out === 1'b1) wb_seen++;
      if (c == 0) begin
        n_cmp++;
        if ({freeze, wb_en_out, dest_out, mem_data_out} !== {1'b1, 1'b1, 4'd3, 32'hDEADBEEF}) begin
          n_err++; $display("FAIL b2b_entry got=%b/%b/%0d/%h exp=1/1/3/deadbeef",
                            freeze, wb_en_out, dest_out, mem_data_out);
        end
      end
      if (c == 1) begin
        n_cmp++;
        if ({sram_we_n, sram_addr, sram_dq_out} !== {1'b0, 18'd4, 16'hF00D}) begin
          n_err++; $display("FAIL b2b_lo got=%b/%h/%h exp=0/4/f00d", sram_we_n, sram_addr, sram_dq_out);
        end
      end
      if (c == 3) begin
        n_cmp++;
        if ({sram_we_n, sram_addr, sram_dq_out} !== {1'b0, 18'd5, 16'h0BAD}) begin
          n_err++; $display("FAIL b2b_hi got=%b/%h/%h exp=0/5/0bad", sram_we_n, sram_addr, sram_dq_out);
        end
      end
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    @(negedge clk);
    n_cmp++;
    if (wb_seen !== 1) begin
      n_err++; $display("FAIL b2b_wb_count got=%0d exp=1", wb_seen);
    end
    n_cmp++;
    if ({sram[4], sram[5]} !== 32'hF00D0BAD) begin
      n_err++; $display("FAIL b2b_mem got=%h exp=f00d0bad", {sram[4], sram[5]});
    end
  endtask

  task automatic test_reset_mid();
    int fz;
    fz = 0;
    tick();
    drive(1'b0, 1'b1, 1'b0, 4'd0, 32'd1036, 32'h12345678);
    tick();
    tick();
    tick();
    @(negedge clk);
    n_cmp++;
    if ({sram_we_n, sram_addr, sram_dq_out} !== {1'b0, 18'd7, 16'h1234}) begin
      n_err++; $display("FAIL rmid_hi got=%b/%h/%h exp=0/7/1234", sram_we_n, sram_addr, sram_dq_out);
    end
    #1;
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 4'd9, 32'd1028, 32'd0);
    #1;
    n_cmp++;
    if ({freeze, sram_we_n, sram_dq_oe, sram_addr} !== {1'b0, 1'b1, 1'b0, 18'd0}) begin
      n_err++; $display("FAIL rmid_pins got=%b/%b/%b/%h exp=0/1/0/0",
                        freeze, sram_we_n, sram_dq_oe, sram_addr);
    end
    n_cmp++;
    if ({wb_en_out, mem_r_out, dest_out, alu_res_out, mem_data_out} !== 70'h0) begin
      n_err++; $display("FAIL rmid_memwb got=%h exp=0",
                        {wb_en_out, mem_r_out, dest_out, alu_res_out, mem_data_out});
    end
    tick();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (freeze === 1'b1) fz++;
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    @(negedge clk);
    n_cmp++;
    if (fz !== 5) begin
      n_err++; $display("FAIL rmid_freeze_cycles got=%0d exp=5", fz);
    end
    n_cmp++;
    if ({wb_en_out, dest_out, mem_data_out} !== {1'b1, 4'd9, 32'hDEADBEEF}) begin
      n_err++; $display("FAIL rmid_load got=%b/%0d/%h exp=1/9/deadbeef", wb_en_out, dest_out, mem_data_out);
    end
    n_cmp++;
    if ({sram[6], sram[7]} !== 32'h56780000) begin
      n_err++; $display("FAIL rmid_mem got=%h exp=56780000", {sram[6], sram[7]});
    end
  endtask

  task automatic test_both_wrap();
    tick();
    drive(1'b1, 1'b1, 1'b1, 4'd2, 32'd1020, 32'hCAFEF00D);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 1) begin
        n_cmp++;
        if ({sram_we_n, sram_oe_n, sram_addr, sram_dq_out} !== {1'b0, 1'b1, 18'h3FFFE, 16'hF00D}) begin
          n_err++; $display("FAIL wrap_lo got=%b/%b/%h/%h exp=0/1/3fffe/f00d",
                            sram_we_n, sram_oe_n, sram_addr, sram_dq_out);
        end
      end
      if (c == 3) begin
        n_cmp++;
        if ({sram_we_n, sram_oe_n, sram_addr, sram_dq_out} !== {1'b0, 1'b1, 18'h3FFFF, 16'hCAFE}) begin
          n_err++; $display("FAIL wrap_hi got=%b/%b/%h/%h exp=0/1/3ffff/cafe",
                            sram_we_n, sram_oe_n, sram_addr, sram_dq_out);
        end
      end
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    @(negedge clk);
    n_cmp++;
    if ({wb_en_out, mem_r_out, dest_out, alu_res_out} !== {1'b1, 1'b1, 4'd2, 32'd1020}) begin
      n_err++; $display("FAIL wrap_memwb got=%b/%b/%0d/%0d exp=1/1/2/1020",
                        wb_en_out, mem_r_out, dest_out, alu_res_out);
    end
    n_cmp++;
    if ({sram[18'h3FFFE], sram[18'h3FFFF]} !== 32'hF00DCAFE) begin
      n_err++; $display("FAIL wrap_mem got=%h exp=f00dcafe", {sram[18'h3FFFE], sram[18'h3FFFF]});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 262144; i++) sram[i] = 16'h0000;
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    test_reset();
    test_nonmem();
    test_store();
    test_load();
    test_back_to_back();
    test_reset_mid();
    test_both_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
